selfcomp_leak_monitor: RTL and testbench
========================================

Name: selfcomp_leak_monitor

Overview:
- Downstream consumer of the two-copy self-composition tester.
- Watches the output handshakes of copy One and copy Two, both fed identical public inputs, and pairs their completions.
- Flags a timing leak whenever the two copies complete in different cycles, records the skew, and counts leak events.
- Reports result divergence as an informational flag only; it is not a leak.

Parameters:
- W, 128, result width of each copy.
- TIMEOUT, 255, cycles a one-sided completion may wait before it is declared a timeout leak; range 1..255.
- SKEW_W, 8, width of the skew register; must satisfy 2^SKEW_W-1 >= TIMEOUT.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- io_clear  in  1  synchronous clear of sticky flags, counters and FSM.
- io_validOne  in  1  copy One output valid.
- io_validTwo  in  1  copy Two output valid.
- io_ready  in  1  shared downstream ready seen by both copies.
- io_resultOne  in  W  copy One result.
- io_resultTwo  in  W  copy Two result.
- bothValid  out  1  combinational: io_validOne & io_validTwo.
- timingLeak  out  1  sticky; set on any skewed, dropped or timed-out completion.
- timingLeakDone  out  1  one-cycle pulse each time a pairing check resolves.
- io_resultDiff  out  1  sticky; set when a resolved pair had unequal results.
- io_skew  out  SKEW_W  skew of the most recently resolved pair, in cycles.
- io_leakCount  out  8  saturating count of leak events, max 255.
- io_state  out  2  FSM state: 0 IDLE, 1 WAIT_TWO, 2 WAIT_ONE.

Behaviour:
- Completion events:
  - fireOne = io_validOne & io_ready.
  - fireTwo = io_validTwo & io_ready.
  - Valid without ready is ignored.
- Reset (reset=0, asynchronous): FSM=IDLE; timingLeak, timingLeakDone, io_resultDiff, io_skew, io_leakCount, the internal wait counter and the captured result all go to 0. This applies immediately, including mid-WAIT.
- Output timing:
  - All outputs except bothValid are registered.
  - The effect of an event at edge t is visible after edge t.
  - timingLeakDone is high for exactly one cycle per resolution.
- IDLE:
  - fireOne & fireTwo: resolve in-sync. skew=0, timingLeak unchanged, resultDiff |= (resultOne != resultTwo), done pulse, stay IDLE.
  - fireOne only: capture resultOne, cnt=1, go to WAIT_TWO.
  - fireTwo only: capture resultTwo, cnt=1, go to WAIT_ONE.
- WAIT_TWO (WAIT_ONE is symmetric with One and Two swapped):
  - fireTwo & !fireOne: resolve late.
    - timingLeak=1, skew=cnt, leakCount+1 (saturating).
    - resultDiff |= (captured != resultTwo), done pulse.
    - Go to IDLE.
  - fireTwo & fireOne: resolve the pending pair as late (same updates as above).
    - Capture the new resultOne, cnt=1, stay in WAIT_TWO.
  - fireOne & !fireTwo: overrun.
    - timingLeak=1, leakCount+1, skew=cnt, done pulse.
    - Replace the captured value with the new resultOne, cnt=1, stay in WAIT_TWO.
  - No fire and cnt==TIMEOUT: timeout.
    - timingLeak=1, skew=TIMEOUT, leakCount+1, done pulse.
    - Go to IDLE; the captured value is discarded and resultDiff is unchanged.
  - No fire and cnt<TIMEOUT: cnt+1.
- Skew definition: One fires at edge t and Two at edge t+k gives io_skew=k, for 1<=k<=TIMEOUT.
- io_leakCount saturates at 255; further leaks still set timingLeak and pulse done.
- io_clear=1:
  - Same effect as reset, but synchronous.
  - Has priority over any fire in the same cycle; those fires are dropped and not counted.
- Result comparison is full W-bit equality.

Test Plan:
- Matched pair: validOne=validTwo=1, ready=1 for one cycle, results 0x1234 both -> done pulses 1 cycle; timingLeak=0, skew=0, resultDiff=0, leakCount=0.
- Skewed pair: validOne at cycle 10, validTwo at cycle 13, ready=1 -> state 1 during cycles 11-13; then timingLeak=1, skew=3, leakCount=1, done pulse once, state 0.
- Timeout: TIMEOUT=8, only validOne fires -> after 8 waiting cycles timingLeak=1, skew=8, leakCount=1, state 0; a later validTwo alone enters WAIT_ONE.
- Divergent in-sync: both fire together with resultOne=5, resultTwo=6 -> resultDiff=1, timingLeak=0, skew=0.
- Gating and overrun:
  - ready=0 while valids are skewed -> no state change and no flags.
  - Two validOne fires with no validTwo -> leakCount=1 (overrun), state stays 1.
- Reset and clear:
  - Assert reset low mid-WAIT_TWO -> all outputs 0 asynchronously, state 0.
  - io_clear concurrent with fireOne -> no capture, state 0, leakCount=0.

Source files
------------

// File: rtl/selfcomp_leak_monitor.sv
// Pairs the output handshakes of two self-composed copies and flags timing leaks
// (skewed, overrun or timed-out completions); result divergence is informational only.
module selfcomp_leak_monitor #(
  parameter int W       = 128,
  parameter int TIMEOUT = 255,
  parameter int SKEW_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_clear,
  input  logic              io_validOne,
  input  logic              io_validTwo,
  input  logic              io_ready,
  input  logic [W-1:0]      io_resultOne,
  input  logic [W-1:0]      io_resultTwo,
  output logic              bothValid,
  output logic              timingLeak,
  output logic              timingLeakDone,
  output logic              io_resultDiff,
  output logic [SKEW_W-1:0] io_skew,
  output logic [7:0]        io_leakCount,
  output logic [1:0]        io_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_TWO = 2'd1,
    WAIT_ONE = 2'd2
  } state_t;

  localparam logic [SKEW_W-1:0] TIMEOUT_V = SKEW_W'(TIMEOUT);
  localparam logic [SKEW_W-1:0] ONE_V     = SKEW_W'(1);

  state_t            state;
  logic [SKEW_W-1:0] cnt;
  logic [W-1:0]      captured;
  logic              fire_one;
  logic              fire_two;
  logic              own_fire;
  logic              other_fire;
  logic [W-1:0]      own_result;
  logic [W-1:0]      other_result;
  logic [7:0]        leak_next;

  assign fire_one  = io_validOne & io_ready;
  assign fire_two  = io_validTwo & io_ready;
  assign bothValid = io_validOne & io_validTwo;
  assign io_state  = state;
  assign leak_next = io_leakCount + {7'd0, (io_leakCount != 8'hFF)};

  // "own" is the copy whose completion is pending, "other" the one still awaited
  always_comb begin
    if (state == WAIT_ONE) begin
      own_fire     = fire_two;
      other_fire   = fire_one;
      own_result   = io_resultTwo;
      other_result = io_resultOne;
    end else begin
      own_fire     = fire_one;
      other_fire   = fire_two;
      own_result   = io_resultOne;
      other_result = io_resultTwo;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      captured       <= '0;
      timingLeak     <= 1'b0;
      timingLeakDone <= 1'b0;
      io_resultDiff  <= 1'b0;
      io_skew        <= '0;
      io_leakCount   <= 8'd0;
    end else if (io_clear) begin
      state          <= IDLE;
      cnt            <= '0;
      captured       <= '0;
      timingLeak     <= 1'b0;
      timingLeakDone <= 1'b0;
      io_resultDiff  <= 1'b0;
      io_skew        <= '0;
      io_leakCount   <= 8'd0;
    end else begin
      timingLeakDone <= 1'b0;
      case (state)
        IDLE: begin
          if (fire_one && fire_two) begin
            io_skew        <= '0;
            timingLeakDone <= 1'b1;
            if (io_resultOne != io_resultTwo) io_resultDiff <= 1'b1;
          end else if (fire_one) begin
            captured <= io_resultOne;
            cnt      <= ONE_V;
            state    <= WAIT_TWO;
          end else if (fire_two) begin
            captured <= io_resultTwo;
            cnt      <= ONE_V;
            state    <= WAIT_ONE;
          end
        end
        WAIT_TWO, WAIT_ONE: begin
          // A fresh own-side fire restarts the wait whether or not the pending pair resolved
          if (own_fire || other_fire) begin
            timingLeak     <= 1'b1;
            io_leakCount   <= leak_next;
            io_skew        <= cnt;
            timingLeakDone <= 1'b1;
            if (other_fire && (captured != other_result)) io_resultDiff <= 1'b1;
            if (own_fire) begin
              captured <= own_result;
              cnt      <= ONE_V;
            end else begin
              state <= IDLE;
            end
          end else if (cnt == TIMEOUT_V) begin
            timingLeak     <= 1'b1;
            io_leakCount   <= leak_next;
            io_skew        <= TIMEOUT_V;
            timingLeakDone <= 1'b1;
            state          <= IDLE;
          end else begin
            cnt <= cnt + ONE_V;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_selfcomp_leak_monitor.sv
// Randomized and directed bench for selfcomp_leak_monitor against a timestamp-based
// pairing model.
module tb_selfcomp_leak_monitor;
  localparam int W       = 128;
  localparam int TIMEOUT = 8;
  localparam int SKEW_W  = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic              io_clear;
  logic              io_validOne;
  logic              io_validTwo;
  logic              io_ready;
  logic [W-1:0]      io_resultOne;
  logic [W-1:0]      io_resultTwo;
  logic              bothValid;
  logic              timingLeak;
  logic              timingLeakDone;
  logic              io_resultDiff;
  logic [SKEW_W-1:0] io_skew;
  logic [7:0]        io_leakCount;
  logic [1:0]        io_state;

  int checks   = 0;
  int failures = 0;

  // Reference model: remembers which copy is pending and the cycle it fired in
  bit           m_pend;
  int           m_side;
  int           m_ptime;
  logic [W-1:0] m_pres;
  bit           m_leak;
  bit           m_done;
  bit           m_diff;
  int           m_skew;
  int           m_cnt;
  int           now;

  selfcomp_leak_monitor #(.W(W), .TIMEOUT(TIMEOUT), .SKEW_W(SKEW_W)) dut (
    .clock(clock), .reset(reset), .io_clear(io_clear),
    .io_validOne(io_validOne), .io_validTwo(io_validTwo), .io_ready(io_ready),
    .io_resultOne(io_resultOne), .io_resultTwo(io_resultTwo),
    .bothValid(bothValid), .timingLeak(timingLeak), .timingLeakDone(timingLeakDone),
    .io_resultDiff(io_resultDiff), .io_skew(io_skew), .io_leakCount(io_leakCount),
    .io_state(io_state)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_pend = 0; m_side = 0; m_ptime = 0; m_pres = '0;
    m_leak = 0; m_done = 0; m_diff = 0; m_skew = 0; m_cnt = 0;
  endtask

  task automatic modelLeak(input int skew);
    m_leak = 1;
    m_done = 1;
    m_skew = skew;
    if (m_cnt < 255) m_cnt++;
  endtask

  // One rising edge of the model, using the inputs currently driven
  task automatic modelStep();
    bit f1, f2, own, other;
    logic [W-1:0] own_r, other_r;
    int elapsed;
    f1 = io_validOne && io_ready;
    f2 = io_validTwo && io_ready;
    m_done = 0;
    if (io_clear) begin
      modelReset();
    end else if (!m_pend) begin
      if (f1 && f2) begin
        m_skew = 0;
        m_done = 1;
        if (io_resultOne != io_resultTwo) m_diff = 1;
      end else if (f1 || f2) begin
        m_pend  = 1;
        m_side  = f1 ? 1 : 2;
        m_ptime = now;
        m_pres  = f1 ? io_resultOne : io_resultTwo;
      end
    end else begin
      elapsed = now - m_ptime;
      own     = (m_side == 1) ? f1 : f2;
      other   = (m_side == 1) ? f2 : f1;
      own_r   = (m_side == 1) ? io_resultOne : io_resultTwo;
      other_r = (m_side == 1) ? io_resultTwo : io_resultOne;
      if (own || other) begin
        modelLeak(elapsed);
        if (other && (m_pres != other_r)) m_diff = 1;
        if (own) begin
          m_ptime = now;
          m_pres  = own_r;
        end else begin
          m_pend = 0;
        end
      end else if (elapsed == TIMEOUT) begin
        modelLeak(TIMEOUT);
        m_pend = 0;
      end
    end
    now++;
  endtask

  task automatic checkAll();
    checkOutput("timingLeak", W'(timingLeak), W'(m_leak));
    checkOutput("done", W'(timingLeakDone), W'(m_done));
    checkOutput("resultDiff", W'(io_resultDiff), W'(m_diff));
    checkOutput("skew", W'(io_skew), W'(m_skew));
    checkOutput("leakCount", W'(io_leakCount), W'(m_cnt));
    checkOutput("state", W'(io_state), m_pend ? W'(m_side) : W'(0));
  endtask

  task automatic applyStimulus(input logic v1, input logic v2, input logic rdy, input logic clr,
                               input logic [W-1:0] r1, input logic [W-1:0] r2);
    @(negedge clock);
    io_validOne  = v1;
    io_validTwo  = v2;
    io_ready     = rdy;
    io_clear     = clr;
    io_resultOne = r1;
    io_resultTwo = r2;
    #1 checkOutput("bothValid", W'(bothValid), W'(v1 & v2));
    @(posedge clock);
    modelStep();
    #1 checkAll();
  endtask

  function automatic logic [W-1:0] randWide();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    logic [W-1:0] base;
    logic [W-1:0] r2;
    bit v1, v2;
    reset = 1'b0; io_clear = 0; io_validOne = 0; io_validTwo = 0; io_ready = 0;
    io_resultOne = '0; io_resultTwo = '0;
    now = 0;
    modelReset();
    repeat (2) @(posedge clock);
    #1 checkAll();
    @(negedge clock);
    reset = 1'b1;

    // Matched pair
    applyStimulus(1, 1, 1, 0, W'(16'h1234), W'(16'h1234));
    checkOutput("matchDone", W'(timingLeakDone), W'(1));
    applyStimulus(0, 0, 1, 0, '0, '0);
    checkOutput("matchDoneOff", W'(timingLeakDone), W'(0));

    // Skewed pair by 3 cycles
    applyStimulus(1, 0, 1, 0, W'(7), '0);
    applyStimulus(0, 0, 1, 0, '0, '0);
    applyStimulus(0, 0, 1, 0, '0, '0);
    applyStimulus(0, 1, 1, 0, '0, W'(7));
    checkOutput("skew3", W'(io_skew), W'(3));
    checkOutput("skewCount", W'(io_leakCount), W'(1));
    checkOutput("skewState", W'(io_state), W'(0));

    // Timeout, then a lone Two enters WAIT_ONE
    applyStimulus(0, 0, 0, 1, '0, '0);
    applyStimulus(1, 0, 1, 0, W'(9), '0);
    repeat (TIMEOUT) applyStimulus(0, 0, 1, 0, '0, '0);
    checkOutput("toSkew", W'(io_skew), W'(TIMEOUT));
    checkOutput("toState", W'(io_state), W'(0));
    applyStimulus(0, 1, 1, 0, '0, W'(9));
    checkOutput("waitOne", W'(io_state), W'(2));

    // Divergent in-sync
    applyStimulus(0, 0, 0, 1, '0, '0);
    applyStimulus(1, 1, 1, 0, W'(5), W'(6));
    checkOutput("divDiff", W'(io_resultDiff), W'(1));
    checkOutput("divLeak", W'(timingLeak), W'(0));

    // Ready gating, then overrun
    applyStimulus(1, 0, 0, 0, W'(1), '0);
    applyStimulus(0, 1, 0, 0, '0, W'(1));
    checkOutput("gateState", W'(io_state), W'(0));
    applyStimulus(1, 0, 1, 0, W'(1), '0);
    applyStimulus(1, 0, 1, 0, W'(2), '0);
    checkOutput("overrunState", W'(io_state), W'(1));

    // Asynchronous reset in the middle of WAIT_TWO
    @(negedge clock);
    io_validOne = 0; io_validTwo = 0;
    #2 reset = 1'b0;
    #1 modelReset();
    checkAll();
    @(negedge clock);
    reset = 1'b1;

    // Clear wins over a concurrent fireOne
    applyStimulus(1, 0, 1, 1, W'(3), '0);
    checkOutput("clrState", W'(io_state), W'(0));

    // Overrun storm drives the leak counter into saturation
    repeat (262) applyStimulus(1, 0, 1, 0, randWide(), '0);
    checkOutput("satCount", W'(io_leakCount), W'(255));
    applyStimulus(1, 0, 1, 0, W'(4), '0);
    checkOutput("satDone", W'(timingLeakDone), W'(1));
    applyStimulus(0, 0, 0, 1, '0, '0);

    // Randomized traffic with quiet windows long enough to time out
    base = randWide();
    for (int i = 0; i < 2500; i++) begin
      if (i % 20 == 0) base = randWide();
      r2 = ($urandom_range(0, 3) == 0) ? (base ^ (W'(1) << $urandom_range(0, W - 1))) : base;
      v1 = ((i % 100) < 85) && ($urandom_range(0, 2) == 0);
      v2 = ((i % 100) < 85) && ($urandom_range(0, 2) == 0);
      applyStimulus(v1, v2, $urandom_range(0, 3) != 0, $urandom_range(0, 399) == 0, base, r2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
